// File: rtl/cmac_link_sequencer_if.sv
// cmac_link_sequencer_if: config, CMAC control and link status bundle for the link sequencer.
// LINK_DROP_COUNT_EN adds the drop_count status field.
interface cmac_link_sequencer_if;
  logic       cfg_rsfec;
  logic [4:0] cfg_txpre;
  logic       link_restart;
  logic       stat_rx_aligned;
  logic       cmac_rsfec_enable;
  logic [4:0] cmac_txpre;
  logic       cmac_reset;
  logic       link_up;
  logic       link_failed;
  logic [3:0] retry_count;
  logic [1:0] seq_state;
`ifdef LINK_DROP_COUNT_EN
  logic [15:0] drop_count;
  modport master (output cfg_rsfec, cfg_txpre, link_restart, stat_rx_aligned,
                  input cmac_rsfec_enable, cmac_txpre, cmac_reset, link_up, link_failed, retry_count, seq_state, drop_count);
  modport slave (input cfg_rsfec, cfg_txpre, link_restart, stat_rx_aligned,
                 output cmac_rsfec_enable, cmac_txpre, cmac_reset, link_up, link_failed, retry_count, seq_state, drop_count);
`else
  modport master (output cfg_rsfec, cfg_txpre, link_restart, stat_rx_aligned,
                  input cmac_rsfec_enable, cmac_txpre, cmac_reset, link_up, link_failed, retry_count, seq_state);
  modport slave (input cfg_rsfec, cfg_txpre, link_restart, stat_rx_aligned,
                 output cmac_rsfec_enable, cmac_txpre, cmac_reset, link_up, link_failed, retry_count, seq_state);
`endif
endinterface

// File: rtl/cmac_link_sequencer.sv
// cmac_link_sequencer: CMAC reset/alignment bring-up and supervision with bounded retries.
// LINK_DROP_COUNT_EN adds a saturating count of alignment losses while up.
module cmac_link_sequencer #(
  parameter int CLK_HZ              = 250000000,
  parameter int RESET_USECS         = 100,
  parameter int ALIGN_TIMEOUT_USECS = 10000,
  parameter int MAX_RETRIES         = 4
) (
  input logic clk,
  input logic reset,
  cmac_link_sequencer_if.slave bus
);
  localparam logic [31:0] RST = 32'((CLK_HZ / 1000000) * RESET_USECS);
  localparam logic [31:0] TMO = 32'((CLK_HZ / 1000000) * ALIGN_TIMEOUT_USECS);
  typedef enum logic [1:0] {HOLD, WAIT, UP, FAIL} state_t;
  state_t state, nxt;
  logic [31:0] timer;
  logic [3:0] retry;
  logic [4:0] txpre;
  logic s1, aligned, rsfec, expire, rs_chg, last, drop_ev, tmo_ev, enter_hold;
  // timer holds the cycles left in the current state, so the final cycle sees 1
  assign expire = timer <= 32'd1;
  assign rs_chg = bus.cfg_rsfec != rsfec && (state == WAIT || state == UP);
  assign last = retry + 4'd1 == 4'(MAX_RETRIES);
  assign drop_ev = state == UP && !aligned && !rs_chg && !bus.link_restart;
  assign tmo_ev = state == WAIT && !aligned && expire && !rs_chg && !bus.link_restart;
  assign enter_hold = nxt == HOLD && (state != HOLD || bus.link_restart);
  always_comb begin
    nxt = state;
    case (state)
      HOLD: nxt = expire ? WAIT : HOLD;
      WAIT: nxt = aligned ? UP : expire ? (last ? FAIL : HOLD) : WAIT;
      UP:   nxt = aligned ? UP : HOLD;
      FAIL: nxt = FAIL;
    endcase
    if (rs_chg) nxt = HOLD;
    if (bus.link_restart) nxt = HOLD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      aligned <= 1'b0;
      state   <= HOLD;
      timer   <= RST;
      retry   <= 4'd0;
      rsfec   <= 1'b1;
      txpre   <= 5'd0;
    end else begin
      s1      <= bus.stat_rx_aligned;
      aligned <= s1;
      state   <= nxt;
      timer   <= enter_hold ? RST : (nxt == WAIT && state != WAIT) ? TMO : timer - 32'(timer != 0);
      retry   <= (bus.link_restart || drop_ev) ? 4'd0 : tmo_ev ? retry + 4'd1 : retry;
      rsfec   <= enter_hold ? bus.cfg_rsfec : rsfec;
      txpre   <= bus.cfg_txpre;
    end
  end
`ifdef LINK_DROP_COUNT_EN
  logic [15:0] drops;
  always_ff @(posedge clk) begin
    if (reset || bus.link_restart) drops <= 16'd0;
    else if (drop_ev && drops != 16'hFFFF) drops <= drops + 16'd1;
  end
  assign bus.drop_count = drops;
`endif
  assign bus.cmac_rsfec_enable = rsfec;
  assign bus.cmac_txpre        = txpre;
  assign bus.cmac_reset        = state == HOLD;
  assign bus.link_up           = state == UP;
  assign bus.link_failed       = state == FAIL;
  assign bus.retry_count       = retry;
  assign bus.seq_state         = state;
endmodule

// File: tb/tb_cmac_link_sequencer.sv
// tb_cmac_link_sequencer: scoreboard bench for bring-up, retries, drops, config changes and reset.
module tb_cmac_link_sequencer;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int n;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sbq[$];
  cmac_link_sequencer_if bus();
  cmac_link_sequencer #(.CLK_HZ(10000000), .RESET_USECS(2), .ALIGN_TIMEOUT_USECS(5), .MAX_RETRIES(3))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [31:0] v);
    sbq.push_back('{tag, v});
  endtask
  task automatic pop(input logic [31:0] got);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got %0h expected none", got);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, got, e.v);
    end
  endtask
  task automatic check_reset_vals;
    push("rst_state", 0); push("rst_cmac_reset", 1); push("rst_rsfec", 1); push("rst_txpre", 0);
    push("rst_link_up", 0); push("rst_failed", 0); push("rst_retry", 0);
    pop(32'(bus.seq_state)); pop(32'(bus.cmac_reset)); pop(32'(bus.cmac_rsfec_enable)); pop(32'(bus.cmac_txpre));
    pop(32'(bus.link_up)); pop(32'(bus.link_failed)); pop(32'(bus.retry_count));
`ifdef LINK_DROP_COUNT_EN
    push("rst_drops", 0); pop(32'(bus.drop_count));
`endif
  endtask
  task automatic wait_while_state(input logic [1:0] s);
    n = 0;
    while (bus.seq_state == s && n < 300) begin tick; n++; end
  endtask
  initial begin
    reset = 1'b1;
    bus.cfg_rsfec = 1'b1;
    bus.cfg_txpre = 5'h11;
    bus.link_restart = 1'b0;
    bus.stat_rx_aligned = 1'b0;
    repeat (3) tick;
    check_reset_vals;
    // bring-up: HOLD length, then alignment appearing as the CMAC leaves reset
    push("hold_len", 20); push("wait_to_up", 3); push("up_retry", 0); push("up_txpre", 5'h11);
    reset = 1'b0;
    n = 0;
    while (bus.cmac_reset && n < 200) begin tick; n++; end
    pop(n);
    bus.stat_rx_aligned = 1'b1;
    n = 0;
    while (!bus.link_up && n < 200) begin tick; n++; end
    pop(n); pop(32'(bus.retry_count)); pop(32'(bus.cmac_txpre));
    // loss of alignment while up
    push("drop_lat", 3); push("drop_cmac_reset", 1); push("drop_state", 0);
`ifdef LINK_DROP_COUNT_EN
    push("drop_cnt1", 1);
`endif
    bus.stat_rx_aligned = 1'b0;
    n = 0;
    while (bus.link_up && n < 200) begin tick; n++; end
    pop(n); pop(32'(bus.cmac_reset)); pop(32'(bus.seq_state));
`ifdef LINK_DROP_COUNT_EN
    pop(32'(bus.drop_count));
`endif
    repeat (7) tick;
    bus.stat_rx_aligned = 1'b1;
    push("reup1", 1);
    n = 0;
    while (!bus.link_up && n < 200) begin tick; n++; end
    pop(32'(bus.link_up));
    // live config changes in UP
    bus.cfg_txpre = 5'h0A;
    push("txpre_live", 5'h0A); push("txpre_up", 1);
    tick;
    pop(32'(bus.cmac_txpre)); pop(32'(bus.link_up));
    bus.cfg_rsfec = 1'b0;
    push("rs_state", 0); push("rs_latched", 0); push("rs_cmac_reset", 1);
    tick;
    pop(32'(bus.seq_state)); pop(32'(bus.cmac_rsfec_enable)); pop(32'(bus.cmac_reset));
    push("reup2", 1);
    n = 0;
    while (!bus.link_up && n < 200) begin tick; n++; end
    pop(32'(bus.link_up));
    // three timed-out attempts into FAIL
    bus.stat_rx_aligned = 1'b0;
    wait_while_state(2'd2);
    for (int a = 1; a <= 3; a++) begin
      push("att_hold", 20); push("att_wait", 50); push("att_retry", a); push("att_state", a == 3 ? 3 : 0);
      wait_while_state(2'd0);
      pop(n);
      wait_while_state(2'd1);
      pop(n); pop(32'(bus.retry_count)); pop(32'(bus.seq_state));
    end
    push("failed", 1); push("fail_sticky", 3);
`ifdef LINK_DROP_COUNT_EN
    push("drop_cnt2", 2);
`endif
    pop(32'(bus.link_failed));
    repeat (5) tick;
    pop(32'(bus.seq_state));
`ifdef LINK_DROP_COUNT_EN
    pop(32'(bus.drop_count));
`endif
    bus.link_restart = 1'b1;
    push("rs_hold", 0); push("rs_creset", 1); push("rs_failed", 0); push("rs_retry", 0);
`ifdef LINK_DROP_COUNT_EN
    push("rs_drops", 0);
`endif
    tick;
    bus.link_restart = 1'b0;
    pop(32'(bus.seq_state)); pop(32'(bus.cmac_reset)); pop(32'(bus.link_failed)); pop(32'(bus.retry_count));
`ifdef LINK_DROP_COUNT_EN
    pop(32'(bus.drop_count));
`endif
    // one timeout, then alignment landing on the final WAIT cycle
    wait_while_state(2'd0);
    wait_while_state(2'd1);
    push("edge_pre_retry", 1);
    pop(32'(bus.retry_count));
    wait_while_state(2'd0);
    repeat (47) tick;
    bus.stat_rx_aligned = 1'b1;
    push("edge_last_wait", 1); push("edge_up", 2); push("edge_retry", 1);
    repeat (2) tick;
    pop(32'(bus.seq_state));
    tick;
    pop(32'(bus.seq_state)); pop(32'(bus.retry_count));
    // reset asserted during WAIT
    bus.stat_rx_aligned = 1'b0;
    wait_while_state(2'd2);
    wait_while_state(2'd0);
    wait_while_state(2'd1);
    wait_while_state(2'd0);
    push("w_state", 1); push("w_retry", 1);
    repeat (5) tick;
    pop(32'(bus.seq_state)); pop(32'(bus.retry_count));
    bus.cfg_txpre = 5'h1F;
    reset = 1'b1;
    tick;
    check_reset_vals;
    reset = 1'b0;
    repeat (2) tick;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
